// File: rtl/button_conditioner.sv
// Raw push-button conditioner: 2-FF synchronizer feeding a debounce FSM with registered
// press/release pulses and a clean level. Long-press pulse built only under BUTTON_CONDITIONER_LONG_PRESS_EN.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 4,
  parameter int unsigned LONG_PRESS_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_raw,
  output logic press_pulse,
  output logic release_pulse,
  output logic btn_level,
  output logic long_press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 || LONG_PRESS_CYCLES < 1) begin : g_param_check
    $error("button_conditioner: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  logic             sync_q1, sync_q2;
  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             press_nxt, release_nxt, level_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= button_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Outputs are registered alongside the state so pulses and level move on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      btn_level     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      btn_level     <= level_nxt;
    end
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (sync_q2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!sync_q2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESSED: begin
        if (!sync_q2) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (sync_q2) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    press_nxt   = (state == PRESS_WAIT) && (state_nxt == PRESSED);
    release_nxt = (state == RELEASE_WAIT) && (state_nxt == IDLE);
    level_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam int unsigned LP_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES);

  logic [LP_W-1:0] lp_timer;

  // Timer restarts only on a fresh accepted press; bounce back into PRESSED keeps it running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lp_timer   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (press_nxt) begin
        lp_timer <= '0;
      end else if ((state == PRESSED || state == RELEASE_WAIT) && lp_timer != LP_MAX) begin
        lp_timer   <= lp_timer + LP_W'(1);
        long_press <= (lp_timer + LP_W'(1)) == LP_MAX;
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule
